// File: rtl/color_sequencer.sv
// Memory-game color sequencer: latches a 4-slot color pattern, shows it slot by slot,
// then checks the player's guesses in order and reports match/mismatch.
module color_sequencer #(
    parameter int unsigned STEP_CYCLES = 25_000_000,
    parameter int unsigned GAP_CYCLES  = 12_500_000,
    parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       pattern_sel,
    input  logic [7:0] pattern_in,
    input  logic       guess_valid,
    input  logic [1:0] guess_color,
    output logic [7:0] colorVec,
    output logic [3:0] slot_en,
    output logic [1:0] guess_idx,
    output logic       busy,
    output logic       round_done,
    output logic       match,
    output logic       mismatch
);

    localparam int unsigned MAX_CYCLES = (STEP_CYCLES > GAP_CYCLES) ? STEP_CYCLES : GAP_CYCLES;
    localparam int unsigned TW         = $clog2(MAX_CYCLES + 1);
    localparam logic [TW-1:0] STEP_LOAD = TW'(STEP_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LOAD  = TW'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StShow,
        StGap,
        StGuess,
        StResult
    } state_t;

    state_t        state;
    logic [TW-1:0] timer;
    logic [1:0]    slot;
    logic [7:0]    lfsr;
    logic          lfsr_fb;
    logic          guess_ok;

    assign lfsr_fb  = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
    assign guess_ok = (guess_color == colorVec[{guess_idx, 1'b0} +: 2]);

    // Free-running so the latched pattern depends on when start arrives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= {lfsr[6:0], lfsr_fb};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= StIdle;
            timer      <= '0;
            slot       <= 2'd0;
            colorVec   <= 8'h00;
            slot_en    <= 4'b0000;
            guess_idx  <= 2'd0;
            busy       <= 1'b0;
            round_done <= 1'b0;
            match      <= 1'b0;
            mismatch   <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (start) begin
                        colorVec  <= pattern_sel ? pattern_in : lfsr;
                        match     <= 1'b0;
                        mismatch  <= 1'b0;
                        slot      <= 2'd0;
                        guess_idx <= 2'd0;
                        slot_en   <= 4'b0001;
                        timer     <= STEP_LOAD;
                        busy      <= 1'b1;
                        state     <= StShow;
                    end
                end
                StShow: begin
                    if (timer == '0) begin
                        slot_en <= 4'b0000;
                        timer   <= GAP_LOAD;
                        state   <= StGap;
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end
                StGap: begin
                    if (timer == '0) begin
                        if (slot == 2'd3) begin
                            state <= StGuess;
                        end else begin
                            slot    <= slot + 2'd1;
                            slot_en <= 4'b0001 << (slot + 2'd1);
                            timer   <= STEP_LOAD;
                            state   <= StShow;
                        end
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end
                StGuess: begin
                    if (guess_valid) begin
                        if (!guess_ok) begin
                            mismatch   <= 1'b1;
                            round_done <= 1'b1;
                            state      <= StResult;
                        end else if (guess_idx == 2'd3) begin
                            match      <= 1'b1;
                            round_done <= 1'b1;
                            state      <= StResult;
                        end else begin
                            guess_idx <= guess_idx + 2'd1;
                        end
                    end
                end
                StResult: begin
                    round_done <= 1'b0;
                    busy       <= 1'b0;
                    state      <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_color_sequencer.sv
// Directed bench for color_sequencer with STEP_CYCLES=4, GAP_CYCLES=2.
module tb_color_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       pattern_sel;
    logic [7:0] pattern_in;
    logic       guess_valid;
    logic [1:0] guess_color;
    logic [7:0] colorVec;
    logic [3:0] slot_en;
    logic [1:0] guess_idx;
    logic       busy;
    logic       round_done;
    logic       match;
    logic       mismatch;

    int checks   = 0;
    int failures = 0;
    logic [3:0] exp_en;

    color_sequencer #(
        .STEP_CYCLES (4),
        .GAP_CYCLES  (2),
        .LFSR_SEED   (8'hA5)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .pattern_sel (pattern_sel),
        .pattern_in  (pattern_in),
        .guess_valid (guess_valid),
        .guess_color (guess_color),
        .colorVec    (colorVec),
        .slot_en     (slot_en),
        .guess_idx   (guess_idx),
        .busy        (busy),
        .round_done  (round_done),
        .match       (match),
        .mismatch    (mismatch)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag, input logic [7:0] exp_vec, input logic exp_match,
                            input logic exp_mismatch);
        chk({tag, "_vec"}, colorVec, exp_vec);
        chk({tag, "_en"}, slot_en, 4'b0000);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_done"}, round_done, 1'b0);
        chk({tag, "_match"}, match, exp_match);
        chk({tag, "_mismatch"}, mismatch, exp_mismatch);
    endtask

    task automatic guess(input logic [1:0] c);
        guess_valid = 1'b1;
        guess_color = c;
        step();
        guess_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        pattern_sel = 1'b0;
        pattern_in = 8'h00;
        guess_valid = 1'b0;
        guess_color = 2'd0;
        @(negedge clk);
        @(negedge clk);
        chk_idle("rst", 8'h00, 1'b0, 1'b0);
        chk("rst_idx", guess_idx, 2'd0);

        // One cycle after release: LFSR A5 -> 4A, outputs unchanged
        rst = 1'b0;
        step();
        chk_idle("post_rst", 8'h00, 1'b0, 1'b0);

        // Round A: LFSR pattern 4A -> slots 2,2,0,1
        start = 1'b1;
        pattern_sel = 1'b0;
        step();
        start = 1'b0;
        chk("a_vec", colorVec, 8'h4A);
        chk("a_en_c1", slot_en, 4'b0001);
        chk("a_busy", busy, 1'b1);
        repeat (24) step();
        chk("a_guess_en", slot_en, 4'b0000);
        chk("a_guess_busy", busy, 1'b1);
        chk("a_idx0", guess_idx, 2'd0);
        guess(2'd2);
        chk("a_idx1", guess_idx, 2'd1);
        guess(2'd2);
        chk("a_idx2", guess_idx, 2'd2);
        guess(2'd0);
        chk("a_idx3", guess_idx, 2'd3);
        chk("a_no_done", round_done, 1'b0);
        guess(2'd1);
        chk("a_match", match, 1'b1);
        chk("a_mismatch", mismatch, 1'b0);
        chk("a_done", round_done, 1'b1);
        chk("a_res_busy", busy, 1'b1);
        step();
        chk_idle("a_idle", 8'h4A, 1'b1, 1'b0);

        // guess_valid while idle has no effect
        guess(2'd3);
        chk_idle("a_idle_gv", 8'h4A, 1'b1, 1'b0);
        chk("a_idle_idx", guess_idx, 2'd3);

        // Round B: pattern E4, slot timing with noise on start/guess/pattern, then mismatch
        start = 1'b1;
        pattern_sel = 1'b1;
        pattern_in = 8'hE4;
        step();
        start = 1'b0;
        chk("b_vec", colorVec, 8'hE4);
        chk("b_en_c1", slot_en, 4'b0001);
        chk("b_match_clr", match, 1'b0);
        chk("b_idx_clr", guess_idx, 2'd0);
        for (int c = 2; c <= 24; c++) begin
            if (c <= 22) begin
                start = c[0];
                guess_valid = 1'b1;
                guess_color = 2'd0;
                pattern_sel = c[1];
                pattern_in = 8'hFF;
            end else begin
                start = 1'b0;
                guess_valid = 1'b0;
            end
            step();
            exp_en = (((c - 1) % 6) < 4) ? (4'b0001 << ((c - 1) / 6)) : 4'b0000;
            chk($sformatf("b_en_c%0d", c), slot_en, exp_en);
        end
        chk("b_vec_hold", colorVec, 8'hE4);
        chk("b_idx_hold", guess_idx, 2'd0);
        step();
        chk("b_guess_en", slot_en, 4'b0000);
        chk("b_guess_busy", busy, 1'b1);
        guess(2'd0);
        chk("b_idx1", guess_idx, 2'd1);
        guess(2'd2);
        chk("b_mismatch", mismatch, 1'b1);
        chk("b_match", match, 1'b0);
        chk("b_done", round_done, 1'b1);
        step();
        chk_idle("b_idle", 8'hE4, 1'b0, 1'b1);

        // Round C: pattern E4, all correct
        start = 1'b1;
        pattern_sel = 1'b1;
        pattern_in = 8'hE4;
        step();
        start = 1'b0;
        chk("c_mismatch_clr", mismatch, 1'b0);
        repeat (24) step();
        guess(2'd0);
        chk("c_idx1", guess_idx, 2'd1);
        guess(2'd1);
        chk("c_idx2", guess_idx, 2'd2);
        guess(2'd2);
        chk("c_idx3", guess_idx, 2'd3);
        guess(2'd3);
        chk("c_match", match, 1'b1);
        chk("c_mismatch", mismatch, 1'b0);
        chk("c_done", round_done, 1'b1);
        step();
        chk_idle("c_idle", 8'hE4, 1'b1, 1'b0);

        // Round D: reset during SHOW of slot 2 (cycles 13-16)
        start = 1'b1;
        pattern_in = 8'h1B;
        step();
        start = 1'b0;
        repeat (13) step();
        chk("d_en_slot2", slot_en, 4'b0100);
        #1 rst = 1'b1;
        #1;
        chk_idle("d_async_rst", 8'h00, 1'b0, 1'b0);
        chk("d_rst_idx", guess_idx, 2'd0);
        rst = 1'b0;
        step();
        chk_idle("d_wait", 8'h00, 1'b0, 1'b0);
        start = 1'b1;
        pattern_sel = 1'b0;
        step();
        start = 1'b0;
        chk("d_lfsr_reseed", colorVec, 8'h4A);
        chk("d_en_slot0", slot_en, 4'b0001);
        chk("d_busy", busy, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
